// File: rtl/dlx_pkg.sv
// Shared types for the DLX memory arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the memory access controller (MAC) state encoding, which is also
// exported on MAC_STATE, and the bus owner encoding shared by the top and
// the fair picker.
package dlx_pkg;

    // MAC state encoding; the numeric values are visible to the I/O sim top.
    typedef enum logic [1:0] {
        MAC_IDLE = 2'd0,
        MAC_ADDR = 2'd1,
        MAC_WAIT = 2'd2,
        MAC_DONE = 2'd3
    } mac_state_e;

    // Bus owner encoding; also the value driven on GNT_MON.
    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_MON  = 1'b1;

endpackage

// File: rtl/dlx_mem_arb_pick.sv
// Two-way fair picker between the DLX core and the I/O monitor.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller only acts on grant when it is able to.
//
// Ports:
//   req_core, req_mon : pending requests
//   last_owner        : owner of the previous transaction (OWN_CORE/OWN_MON)
//   grant             : at least one request is pending
//   owner             : chosen requester; on a tie, the one that did not go last
module dlx_mem_arb_pick
    import dlx_pkg::*;
(
    input  logic req_core,
    input  logic req_mon,
    input  logic last_owner,
    output logic grant,
    output logic owner
);

    always_comb begin
        grant = req_core | req_mon;
        owner = last_owner;
        if (req_mon && !req_core) begin
            owner = OWN_MON;
        end else if (req_core && !req_mon) begin
            owner = OWN_CORE;
        end else if (req_core && req_mon) begin
            // Alternate on a tie so neither side can starve the other.
            owner = ~last_owner;
        end
    end

endmodule

// File: rtl/dlx_mem_arbiter.sv
// Arbitrates the external memory bus between the DLX core and the I/O monitor.
// Latency: request sampled in cycle n, DONE in cycle n+3 plus one per extra wait cycle.
// Backpressure: requesters hold request and operands until their DONE pulse; ACK_N stalls WAIT.
//
// Ports:
//   CLK_IN, RST_N            : clock (rising edge), asynchronous active-low reset
//   C_MR/C_MW/C_AO/C_DO      : core read/write request, address, write data
//   C_DI/C_BUSY/C_DONE       : core read data (registered), pending flag, completion pulse
//   M_REQ/M_WR/M_AO/M_DO     : monitor request, write select, address, write data
//   M_DI/M_DONE              : monitor read data (registered), completion pulse
//   AS_N/WR_N/AO/DO/DI/ACK_N : external memory bus
//   MAC_STATE                : controller state (0 IDLE, 1 ADDR, 2 WAIT, 3 DONE)
//   GNT_MON                  : current or last owner is the monitor
//   BUS_ERR                  : timeout abort pulse, coincident with the owner's DONE
//
// Optional feature macro: BUS_TIMEOUT_EN. When defined, a WAIT that sees no
// ACK_N for TIMEOUT_CYCLES cycles is aborted through DONE with BUS_ERR and a
// zero read result. When undefined, WAIT waits forever and BUS_ERR is 0.
module dlx_mem_arbiter
    import dlx_pkg::*;
#(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic          CLK_IN,
    input  logic          RST_N,
    // core port
    input  logic          C_MR,
    input  logic          C_MW,
    input  logic [AW-1:0] C_AO,
    input  logic [DW-1:0] C_DO,
    output logic [DW-1:0] C_DI,
    output logic          C_BUSY,
    output logic          C_DONE,
    // monitor port
    input  logic          M_REQ,
    input  logic          M_WR,
    input  logic [AW-1:0] M_AO,
    input  logic [DW-1:0] M_DO,
    output logic [DW-1:0] M_DI,
    output logic          M_DONE,
    // external memory bus
    output logic          AS_N,
    output logic          WR_N,
    output logic [AW-1:0] AO,
    output logic [DW-1:0] DO,
    input  logic [DW-1:0] DI,
    input  logic          ACK_N,
    // status
    output logic [1:0]    MAC_STATE,
    output logic          GNT_MON,
    output logic          BUS_ERR
);

    // The limit has to fit the 8-bit wait counter and be non-zero.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("dlx_mem_arbiter: TIMEOUT_CYCLES must be in 1..255");
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    mac_state_e    state_q,   state_d;
    logic          owner_q,   owner_d;     // doubles as last_owner
    logic          as_n_q,    as_n_d;
    logic          wr_n_q,    wr_n_d;
    logic [AW-1:0] ao_q,      ao_d;
    logic [DW-1:0] do_q,      do_d;
    logic [DW-1:0] c_di_q,    c_di_d;
    logic [DW-1:0] m_di_q,    m_di_d;
    logic          c_done_q,  c_done_d;
    logic          m_done_q,  m_done_d;
    logic          bus_err_q, bus_err_d;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0]    wait_cnt_q, wait_cnt_d;
    logic [7:0]    wait_cnt_inc;
`endif

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic req_core;
    logic pick_grant;
    logic pick_owner;

    // A core access is pending on either strobe; both high means write.
    assign req_core = C_MR | C_MW;

    dlx_mem_arb_pick u_pick (
        .req_core   (req_core),
        .req_mon    (M_REQ),
        .last_owner (owner_q),
        .grant      (pick_grant),
        .owner      (pick_owner)
    );

`ifdef BUS_TIMEOUT_EN
    assign wait_cnt_inc = wait_cnt_q + 8'd1;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        as_n_d    = as_n_q;
        wr_n_d    = wr_n_q;
        ao_d      = ao_q;
        do_d      = do_q;
        c_di_d    = c_di_q;
        m_di_d    = m_di_q;
        // completion flags are single-cycle pulses
        c_done_d  = 1'b0;
        m_done_d  = 1'b0;
        bus_err_d = 1'b0;
`ifdef BUS_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
`endif

        case (state_q)
            MAC_IDLE: begin
                if (pick_grant) begin
                    owner_d = pick_owner;
                    as_n_d  = 1'b0;
                    state_d = MAC_ADDR;
                    if (pick_owner == OWN_MON) begin
                        ao_d   = M_AO;
                        do_d   = M_DO;
                        wr_n_d = ~M_WR;
                    end else begin
                        ao_d   = C_AO;
                        do_d   = C_DO;
                        wr_n_d = ~C_MW;
                    end
                end
            end

            MAC_ADDR: begin
                // Strobe lasts exactly one cycle; ACK_N is not looked at yet.
                as_n_d  = 1'b1;
                state_d = MAC_WAIT;
`ifdef BUS_TIMEOUT_EN
                wait_cnt_d = 8'd0;
`endif
            end

            MAC_WAIT: begin
                if (!ACK_N) begin
                    state_d = MAC_DONE;
                    wr_n_d  = 1'b1;
                    if (owner_q == OWN_MON) begin
                        m_done_d = 1'b1;
                        if (wr_n_q) begin
                            m_di_d = DI;
                        end
                    end else begin
                        c_done_d = 1'b1;
                        if (wr_n_q) begin
                            c_di_d = DI;
                        end
                    end
                end
`ifdef BUS_TIMEOUT_EN
                else begin
                    wait_cnt_d = wait_cnt_inc;
                    if (wait_cnt_inc == TO_LIMIT) begin
                        // Abort: complete the access with a zero read result.
                        state_d   = MAC_DONE;
                        wr_n_d    = 1'b1;
                        bus_err_d = 1'b1;
                        if (owner_q == OWN_MON) begin
                            m_done_d = 1'b1;
                            if (wr_n_q) begin
                                m_di_d = '0;
                            end
                        end else begin
                            c_done_d = 1'b1;
                            if (wr_n_q) begin
                                c_di_d = '0;
                            end
                        end
                    end
                end
`endif
            end

            MAC_DONE: begin
                // The DONE cycle never grants, so a requester can drop its
                // request before arbitration looks at it again.
                state_d = MAC_IDLE;
            end

            default: begin
                state_d = MAC_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= MAC_IDLE;
            owner_q   <= OWN_CORE;
            as_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            ao_q      <= '0;
            do_q      <= '0;
            c_di_q    <= '0;
            m_di_q    <= '0;
            c_done_q  <= 1'b0;
            m_done_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            as_n_q    <= as_n_d;
            wr_n_q    <= wr_n_d;
            ao_q      <= ao_d;
            do_q      <= do_d;
            c_di_q    <= c_di_d;
            m_di_q    <= m_di_d;
            c_done_q  <= c_done_d;
            m_done_q  <= m_done_d;
            bus_err_q <= bus_err_d;
        end
    end

`ifdef BUS_TIMEOUT_EN
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign AS_N      = as_n_q;
    assign WR_N      = wr_n_q;
    assign AO        = ao_q;
    assign DO        = do_q;
    assign C_DI      = c_di_q;
    assign M_DI      = m_di_q;
    assign C_DONE    = c_done_q;
    assign M_DONE    = m_done_q;
    assign GNT_MON   = owner_q;
    assign MAC_STATE = state_q;
    assign C_BUSY    = req_core & ~c_done_q;

`ifdef BUS_TIMEOUT_EN
    assign BUS_ERR = bus_err_q;
`else
    assign BUS_ERR = 1'b0;
`endif

endmodule
